jzjpcc_fetch: RTL and testbench

//  Fetch stage of the jzjpcc 5-stage RV32I core. Owns the program counter and drives the

---
 rtl/jzjpcc_pkg.sv | 15 +
 rtl/jzjpcc_pc_register.sv | 42 ++++
 rtl/jzjpcc_fetch.sv | 137 +++++++++++++
 tb/tb_jzjpcc_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc core front end: the NOP encoding used
// for pipeline bubbles and the fetch control-mode enumeration.
package jzjpcc_pkg;

    // addi x0,x0,0 with the always-11 opcode bits [1:0] dropped.
    localparam logic [29:0] JZJPCC_NOP_UPPER = 30'h0000_0004;

    // Per-cycle fetch control mode, priority REDIRECT > STALL > NORMAL.
    typedef enum logic [1:0] {
        FETCH_NORMAL   = 2'd0,
        FETCH_STALL    = 2'd1,
        FETCH_REDIRECT = 2'd2
    } fetch_mode_e;

endpackage

// File: rtl/jzjpcc_pc_register.sv
// Program counter of the jzjpcc fetch stage. Holds a word index and selects
// the next value from increment, hold or redirect target according to the
// fetch mode decided by jzjpcc_fetch.
module jzjpcc_pc_register
    import jzjpcc_pkg::*;
#(
    parameter int unsigned       PC_W     = 14,
    parameter logic [PC_W-1:0]   RESET_PC = {PC_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  fetch_mode_e       mode_i,
    input  logic [PC_W-1:0]   target_i,
    output logic [PC_W-1:0]   pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next-PC mux; the increment wraps naturally at the word-index width.
    always_comb begin
        pc_d = pc_q;
        case (mode_i)
            FETCH_REDIRECT: pc_d = target_i;
            FETCH_STALL:    pc_d = pc_q;
            FETCH_NORMAL:   pc_d = pc_q + PC_W'(1);
            default:        pc_d = pc_q;
        endcase
    end

    // PC flop with asynchronous active-low reset to the reset vector.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/jzjpcc_fetch.sv
// Fetch stage of the jzjpcc 5-stage RV32I core. Drives the instruction
// memory word address from the PC and registers {instruction, PC, valid}
// into the fetch->decode pipeline register. A taken branch redirects the PC
// and squashes the wrong-path instruction into a NOP bubble; a stall holds
// the PC and the pipeline register.
// Optional: define JZJPCC_FETCH_PERF_EN to add the fetchCount counter port.
module jzjpcc_fetch
    import jzjpcc_pkg::*;
#(
    parameter int unsigned PC_MAX_B     = 15,
    parameter int unsigned RESET_VECTOR = 32'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [PC_MAX_B-2:0]   imemAddress,
    input  logic [29:0]           imemData,
    input  logic                  stall_fetch,
    input  logic                  branchTaken,
    input  logic [PC_MAX_B-2:0]   branchTarget,
    output logic [29:0]           instruction_decode,
    output logic [PC_MAX_B-2:0]   currentPC_decode,
`ifdef JZJPCC_FETCH_PERF_EN
    output logic [31:0]           fetchCount,
`endif
    output logic                  valid_decode
);

    localparam int unsigned      PC_W     = PC_MAX_B - 1;
    localparam logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_VECTOR);

    fetch_mode_e      mode_s;
    logic [PC_W-1:0]  pc_s;

    logic [29:0]      instr_q;
    logic [29:0]      instr_d;
    logic [PC_W-1:0]  dpc_q;
    logic [PC_W-1:0]  dpc_d;
    logic             valid_q;
    logic             valid_d;

    // Mode decode: a taken branch overrides a stall request.
    always_comb begin
        mode_s = FETCH_NORMAL;
        if (branchTaken) begin
            mode_s = FETCH_REDIRECT;
        end else if (stall_fetch) begin
            mode_s = FETCH_STALL;
        end else begin
            mode_s = FETCH_NORMAL;
        end
    end

    jzjpcc_pc_register #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clock    (clock),
        .reset    (reset),
        .mode_i   (mode_s),
        .target_i (branchTarget),
        .pc_o     (pc_s)
    );

    assign imemAddress = pc_s;

    // Fetch->decode register next state: load, hold, or inject a bubble.
    always_comb begin
        instr_d = instr_q;
        dpc_d   = dpc_q;
        valid_d = valid_q;
        case (mode_s)
            FETCH_REDIRECT: begin
                instr_d = JZJPCC_NOP_UPPER;
                dpc_d   = pc_s;
                valid_d = 1'b0;
            end
            FETCH_STALL: begin
                instr_d = instr_q;
                dpc_d   = dpc_q;
                valid_d = valid_q;
            end
            FETCH_NORMAL: begin
                instr_d = imemData;
                dpc_d   = pc_s;
                valid_d = 1'b1;
            end
            default: begin
                instr_d = instr_q;
                dpc_d   = dpc_q;
                valid_d = valid_q;
            end
        endcase
    end

    // Fetch->decode register; reset presents a NOP bubble at the reset PC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= JZJPCC_NOP_UPPER;
            dpc_q   <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            dpc_q   <= dpc_d;
            valid_q <= valid_d;
        end
    end

    assign instruction_decode = instr_q;
    assign currentPC_decode   = dpc_q;
    assign valid_decode       = valid_q;

`ifdef JZJPCC_FETCH_PERF_EN
    logic [31:0] count_q;
    logic [31:0] count_d;

    // Count only edges that load a real instruction into decode.
    always_comb begin
        if (mode_s == FETCH_NORMAL) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Performance counter register, wraps at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetchCount = count_q;
`endif

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// Self-checking bench for jzjpcc_fetch: directed vector table, async reset
// sequence, PC wrap on a narrow instance, and randomized traffic against a
// cycle-level reference model of the fetch rules.
module tb_jzjpcc_fetch;

    localparam logic [29:0] NOP = 30'h0000_0004;

    logic         clk;
    logic         rst_n;
    logic [13:0]  addr;
    logic [29:0]  data;
    logic         stall;
    logic         br;
    logic [13:0]  tgt;
    logic [29:0]  instr;
    logic [13:0]  dpc;
    logic         valid;
`ifdef JZJPCC_FETCH_PERF_EN
    logic [31:0]  cnt;
`endif

    logic [2:0]   s_addr;
    logic [29:0]  s_data;
    logic         s_stall;
    logic         s_br;
    logic [2:0]   s_tgt;
    logic [29:0]  s_instr;
    logic [2:0]   s_dpc;
    logic         s_valid;
`ifdef JZJPCC_FETCH_PERF_EN
    logic [31:0]  s_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [29:0] mem_f(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'd2654435761) ^ 32'h15A5_3C3C;
        return h[29:0];
    endfunction

    assign data   = mem_f({18'd0, addr});
    assign s_data = mem_f({29'd0, s_addr});

    jzjpcc_fetch #(.PC_MAX_B(15), .RESET_VECTOR(32'h10)) dut (
        .clock              (clk),
        .reset              (rst_n),
        .imemAddress        (addr),
        .imemData           (data),
        .stall_fetch        (stall),
        .branchTaken        (br),
        .branchTarget       (tgt),
        .instruction_decode (instr),
        .currentPC_decode   (dpc),
`ifdef JZJPCC_FETCH_PERF_EN
        .fetchCount         (cnt),
`endif
        .valid_decode       (valid)
    );

    jzjpcc_fetch #(.PC_MAX_B(4), .RESET_VECTOR(32'd0)) dut_small (
        .clock              (clk),
        .reset              (rst_n),
        .imemAddress        (s_addr),
        .imemData           (s_data),
        .stall_fetch        (s_stall),
        .branchTaken        (s_br),
        .branchTarget       (s_tgt),
        .instruction_decode (s_instr),
        .currentPC_decode   (s_dpc),
`ifdef JZJPCC_FETCH_PERF_EN
        .fetchCount         (s_cnt),
`endif
        .valid_decode       (s_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        br;
        logic        st;
        logic [13:0] tgt;
        logic [13:0] e_addr;
        logic [13:0] e_dpc;
        logic        e_valid;
    } vec_t;

    vec_t vt[9];

    // Reference model state
    int unsigned m_pc, m_dpc, m_cnt;
    logic [29:0] m_instr;
    logic        m_valid;

    task automatic model_reset(input int unsigned rv);
        m_pc = rv; m_dpc = rv; m_instr = NOP; m_valid = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic b, input logic s, input int unsigned t);
        if (b) begin
            m_instr = NOP; m_dpc = m_pc; m_valid = 1'b0; m_pc = t;
        end else if (!s) begin
            m_instr = mem_f(m_pc); m_dpc = m_pc; m_valid = 1'b1;
            m_pc = (m_pc + 1) % 16384;
            m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 14'd0;
        s_stall = 1'b0; s_br = 1'b0; s_tgt = 3'd0;

        // Directed vectors: {branch, stall, target} -> {addr, decode pc, valid}
        vt[0] = '{1'b0, 1'b0, 14'h000, 14'h011, 14'h010, 1'b1};
        vt[1] = '{1'b0, 1'b0, 14'h000, 14'h012, 14'h011, 1'b1};
        vt[2] = '{1'b1, 1'b0, 14'h030, 14'h030, 14'h012, 1'b0};
        vt[3] = '{1'b1, 1'b1, 14'h100, 14'h100, 14'h030, 1'b0};
        vt[4] = '{1'b0, 1'b0, 14'h000, 14'h101, 14'h100, 1'b1};
        vt[5] = '{1'b0, 1'b1, 14'h000, 14'h101, 14'h100, 1'b1};
        vt[6] = '{1'b0, 1'b1, 14'h000, 14'h101, 14'h100, 1'b1};
        vt[7] = '{1'b0, 1'b1, 14'h000, 14'h101, 14'h100, 1'b1};
        vt[8] = '{1'b0, 1'b0, 14'h000, 14'h102, 14'h101, 1'b1};

        #12;
        chk("reset_addr",  {18'd0, addr}, 32'h10);
        chk("reset_instr", {2'd0, instr}, {2'd0, NOP});
        chk("reset_dpc",   {18'd0, dpc},  32'h10);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_small_addr", {29'd0, s_addr}, 32'd0);
`ifdef JZJPCC_FETCH_PERF_EN
        chk("reset_count", cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            br = vt[i].br; stall = vt[i].st; tgt = vt[i].tgt;
            tick();
            chk($sformatf("vec%0d_addr", i),  {18'd0, addr}, {18'd0, vt[i].e_addr});
            chk($sformatf("vec%0d_dpc", i),   {18'd0, dpc},  {18'd0, vt[i].e_dpc});
            chk($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_instr", i), {2'd0, instr},
                vt[i].e_valid ? {2'd0, mem_f({18'd0, vt[i].e_dpc})} : {2'd0, NOP});
        end

        // Async reset asserted between edges while stalled
        br = 1'b0; stall = 1'b1;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr",  {18'd0, addr}, 32'h10);
        chk("async_rst_instr", {2'd0, instr}, {2'd0, NOP});
        chk("async_rst_dpc",   {18'd0, dpc},  32'h10);
        chk("async_rst_valid", {31'd0, valid}, 32'd0);
`ifdef JZJPCC_FETCH_PERF_EN
        chk("async_rst_count", cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_addr", {18'd0, addr}, 32'h15);
        chk("post_rst_dpc",  {18'd0, dpc},  32'h14);
`ifdef JZJPCC_FETCH_PERF_EN
        chk("post_rst_count", cnt, 32'd5);
`endif

        // PC wrap on the 3-bit instance: redirect to 7, then increment
        s_br = 1'b1; s_tgt = 3'd7;
        tick();
        chk("wrap_target", {29'd0, s_addr}, 32'd7);
        s_br = 1'b0;
        tick();
        chk("wrap_addr",  {29'd0, s_addr}, 32'd0);
        chk("wrap_dpc",   {29'd0, s_dpc},  32'd7);
        chk("wrap_instr", {2'd0, s_instr}, {2'd0, mem_f(32'd7)});
        tick();
        chk("wrap_next",  {29'd0, s_addr}, 32'd1);

        // Randomized traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(32'h10);
        for (int n = 0; n < 400; n++) begin
            br    = ($urandom_range(7) == 0);
            stall = ($urandom_range(3) == 0);
            tgt   = 14'($urandom);
            model_step(br, stall, {18'd0, tgt});
            tick();
            chk("rand_addr",  {18'd0, addr}, m_pc);
            chk("rand_dpc",   {18'd0, dpc},  m_dpc);
            chk("rand_valid", {31'd0, valid}, {31'd0, m_valid});
            chk("rand_instr", {2'd0, instr}, {2'd0, m_instr});
`ifdef JZJPCC_FETCH_PERF_EN
            chk("rand_count", cnt, m_cnt);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
